// File: rtl/wb_pkg.sv
// Shared definitions for the IICMB Wishbone responder: register addresses,
// register layouts, command codes, FSM states and the latency helper.
package wb_pkg;

  localparam int CSR_ADDR  = 0;
  localparam int DPR_ADDR  = 1;
  localparam int CMDR_ADDR = 2;
  localparam int FSMR_ADDR = 3;

  // Wide enough for the longest Wait (255 * WAIT_SCALE) at sane scales.
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    CMD_WAIT     = 3'b000,
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110,
    CMD_RSVD     = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic       e;
    logic       ie;
    logic       bb;
    logic       bc;
    logic [3:0] bus_id;
  } csr_s;

  typedef union packed {
    csr_s       f;
    logic [7:0] raw;
  } csr_u;

  typedef struct packed {
    logic don;
    logic nak;
    logic al;
    logic err;
    logic r;
    cmd_e cmd;
  } cmdr_s;

  typedef union packed {
    cmdr_s      f;
    logic [7:0] raw;
  } cmdr_u;

  // Completion outcome; exactly one bit is set when a command finishes.
  typedef struct packed {
    logic don;
    logic nak;
    logic err;
  } status_s;

  // Execution length minus one, as loaded into the EXEC down-counter.
  function automatic logic [CNT_W-1:0] cmd_latency_m1(input cmd_e       cmd,
                                                      input logic [7:0] dpr,
                                                      input int         cmd_latency,
                                                      input int         wait_scale);
    int lat;
    lat = (cmd == CMD_WAIT) ? int'(dpr) * wait_scale : cmd_latency;
    if (lat < 1) lat = 1;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/iicmb_cmd_exec.sv
// Abstract byte-command engine: IDLE -> EXEC -> DONE FSM, latency counter,
// receive counter, bus-captured/bus-busy flags and the completion outcome.
module iicmb_cmd_exec
  import wb_pkg::*;
#(
  parameter int         NUM_BUSES   = 16,
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         CMD_LATENCY = 4,
  parameter int         WAIT_SCALE  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic        abort,
  input  cmd_e        cmd,
  input  logic [7:0]  dpr,
  output resp_state_e state,
  output logic        bc,
  output logic        bb,
  output logic        done,
  output status_s     status,
  output logic        rx_we,
  output logic [7:0]  rx_data,
  output logic        bus_we,
  output logic [3:0]  bus_id
);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_e             cmd_q;
  logic [7:0]       dpr_q;
  logic             bc_q, bb_q, first_q;
  logic [7:0]       rx_cnt_q;

  // Next-state and latency counter control.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
          cnt_d   = cmd_latency_m1(cmd, dpr, CMD_LATENCY, WAIT_SCALE);
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Clearing E wins over anything in flight.
    if (abort) state_d = ST_IDLE;
  end

  // State register; command and operand are captured when a command starts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_WAIT;
      dpr_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        cmd_q <= cmd;
        dpr_q <= dpr;
      end
    end
  end

  assign done = (state_q == ST_DONE) && !abort;

  // Outcome of the captured command, evaluated against current bus flags.
  always_comb begin
    status = '0;
    rx_we  = 1'b0;
    bus_we = 1'b0;
    case (cmd_q)
      CMD_WRITE: begin
        if (!bc_q)                                    status.err = 1'b1;
        else if (first_q && dpr_q[7:1] != SLAVE_ADDR) status.nak = 1'b1;
        else                                          status.don = 1'b1;
      end
      CMD_READ_ACK, CMD_READ_NAK: begin
        if (!bc_q) status.err = 1'b1;
        else begin
          status.don = 1'b1;
          rx_we      = done;
        end
      end
      CMD_START, CMD_STOP, CMD_WAIT: status.don = 1'b1;
      CMD_SET_BUS: begin
        if (int'(dpr_q) < NUM_BUSES) begin
          status.don = 1'b1;
          bus_we     = done;
        end else begin
          status.err = 1'b1;
        end
      end
      default: status.err = 1'b1;
    endcase
  end

  // Bus flags, address-phase tracking and receive counter update on DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bc_q     <= 1'b0;
      bb_q     <= 1'b0;
      first_q  <= 1'b0;
      rx_cnt_q <= '0;
    end else if (done) begin
      case (cmd_q)
        CMD_START: begin
          bc_q     <= 1'b1;
          bb_q     <= 1'b1;
          first_q  <= 1'b1;
          rx_cnt_q <= '0;
        end
        CMD_STOP: begin
          bc_q    <= 1'b0;
          bb_q    <= 1'b0;
          first_q <= 1'b0;
        end
        CMD_WRITE:                  first_q <= 1'b0;
        CMD_READ_ACK, CMD_READ_NAK: if (bc_q) rx_cnt_q <= rx_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign bc      = bc_q;
  assign bb      = bb_q;
  assign rx_data = rx_cnt_q;
  assign bus_id  = dpr_q[3:0];

endmodule

// File: rtl/iicmb_wb_responder.sv
// IICMB register block on the Wishbone slave side: bus decode, CSR/DPR/CMDR
// storage and the level completion interrupt. Command execution lives in
// iicmb_cmd_exec. Define IICMB_WB_RESP_FSMR_EN to expose the read-only FSMR
// at address 3; otherwise address 3 reads 0.
module iicmb_wb_responder
  import wb_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 2,
  parameter int         DATA_WIDTH  = 8,
  parameter int         NUM_BUSES   = 16,
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         CMD_LATENCY = 4,
  parameter int         WAIT_SCALE  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o
);

  logic       accept, wr, rd;
  logic       sel_csr, sel_dpr, sel_cmdr;
  logic [7:0] wdata;

  logic       e_q, ie_q, irq_q;
  logic [7:0] dpr_q;
  logic [3:0] bus_id_q;
  cmd_e       cmd_q;
  status_s    st_q;

  resp_state_e ex_state;
  logic        ex_bc, ex_bb, ex_done, ex_rx_we, ex_bus_we, busy;
  logic        cmd_start, abort;
  status_s     ex_status;
  logic [7:0]  ex_rx_data;
  logic [3:0]  ex_bus_id;

  csr_u       csr_view;
  cmdr_u      cmdr_view;
  logic [7:0] rd_data;

  // A new request is taken only while ack_o is low, so held requests are
  // acknowledged every other cycle.
  assign accept   = cyc_i && stb_i && !ack_o;
  assign wr       = accept && we_i;
  assign rd       = accept && !we_i;
  assign sel_csr  = (adr_i == ADDR_WIDTH'(CSR_ADDR));
  assign sel_dpr  = (adr_i == ADDR_WIDTH'(DPR_ADDR));
  assign sel_cmdr = (adr_i == ADDR_WIDTH'(CMDR_ADDR));
  assign wdata    = dat_i[7:0];

  assign busy      = (ex_state != ST_IDLE);
  assign cmd_start = wr && sel_cmdr && e_q && !busy;
  assign abort     = wr && sel_csr && !wdata[7];

  iicmb_cmd_exec #(
    .NUM_BUSES   (NUM_BUSES),
    .SLAVE_ADDR  (SLAVE_ADDR),
    .CMD_LATENCY (CMD_LATENCY),
    .WAIT_SCALE  (WAIT_SCALE)
  ) u_exec (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (cmd_start),
    .abort   (abort),
    .cmd     (cmd_e'(wdata[2:0])),
    .dpr     (dpr_q),
    .state   (ex_state),
    .bc      (ex_bc),
    .bb      (ex_bb),
    .done    (ex_done),
    .status  (ex_status),
    .rx_we   (ex_rx_we),
    .rx_data (ex_rx_data),
    .bus_we  (ex_bus_we),
    .bus_id  (ex_bus_id)
  );

  assign csr_view.f  = csr_s'{e: e_q, ie: ie_q, bb: ex_bb, bc: ex_bc, bus_id: bus_id_q};
  assign cmdr_view.f = cmdr_s'{don: st_q.don, nak: st_q.nak, al: 1'b0,
                               err: st_q.err, r: 1'b0, cmd: cmd_q};

  // Register read multiplexer; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (sel_csr)       rd_data = csr_view.raw;
    else if (sel_dpr)  rd_data = dpr_q;
    else if (sel_cmdr) rd_data = cmdr_view.raw;
`ifdef IICMB_WB_RESP_FSMR_EN
    else if (adr_i == ADDR_WIDTH'(FSMR_ADDR)) rd_data = {4'b0000, ex_state, ex_bc, busy};
`else
    else if (adr_i == ADDR_WIDTH'(FSMR_ADDR)) rd_data = '0;
`endif
  end

  // Wishbone response: one-cycle ack, read data held only while acked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= accept;
      dat_o <= rd ? DATA_WIDTH'(rd_data) : '0;
    end
  end

  // Register storage, completion status and interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q      <= 1'b0;
      ie_q     <= 1'b0;
      dpr_q    <= '0;
      bus_id_q <= '0;
      cmd_q    <= CMD_WAIT;
      st_q     <= status_s'{don: 1'b1, nak: 1'b0, err: 1'b0};
      irq_q    <= 1'b0;
    end else begin
      if (wr && sel_csr) begin
        e_q  <= wdata[7];
        ie_q <= wdata[6];
      end
      if (ex_done) begin
        st_q <= ex_status;
        if (ex_rx_we)  dpr_q    <= ex_rx_data;
        if (ex_bus_we) bus_id_q <= ex_bus_id;
      end
      if (wr && sel_dpr) dpr_q <= wdata;
      if (cmd_start) begin
        cmd_q <= cmd_e'(wdata[2:0]);
        st_q  <= '0;
      end
      // Completion wins over a CMDR read in the same cycle.
      if (ex_done && ie_q)    irq_q <= 1'b1;
      else if (rd && sel_cmdr) irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;

endmodule
